// File: rtl/memory_interface.sv
// -----------------------------------------------------------------------------
// memory_interface
//
// Sequencer between the core control unit and a unified 32-bit synchronous
// SRAM. One access (instruction fetch or RV64 byte/half/word/double
// load/store) is accepted per `start` level seen in IDLE and is split into
// 1..3 RAM beats with byte enables. Load data is assembled from the beats,
// shifted down by the byte offset, and sign- or zero-extended to 64 bits.
// Completion is a single-cycle `done` pulse.
//
// Optional feature macro: MEM_MISALIGNED_EN
//   defined   : any byte offset is served (up to 3 beats), misaligned is 0
//   undefined : addr[size-1:0] != 0 is rejected without touching the RAM
//
// Handshake: `start` is a level, sampled only in IDLE. Once accepted, all
// request inputs are latched and ignored until the access completes. `done`
// pulses in the DONE state; the earliest next accept is the following cycle,
// so a continuously held `start` produces back-to-back accesses.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             request level
//   operation         0 = read, 1 = write
//   size              00 byte, 01 half, 10 word, 11 double
//   extension         funct3; bit 2 set = zero-extend, clear = sign-extend
//   addr, wdata       byte address, store data (low 2^size bytes used)
//   rdata             registered, extended load result
//   done, busy        completion pulse, high outside IDLE
//   misaligned        access was rejected (held until next accept)
//   ram_*             registered SRAM port; ram_rdata valid the cycle after ram_re
//   state_dbg         current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
// -----------------------------------------------------------------------------
module memory_interface #(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              operation,
    input  logic [1:0]        size,
    input  logic [2:0]        extension,
    input  logic [63:0]       addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              misaligned,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;

    // Latched request
    logic              op_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic [1:0]        off_q;
    logic [RAM_AW-1:0] base_q;
    logic [1:0]        beats_q;
    logic [1:0]        beat_q;     // index of the beat currently on the RAM port
    logic [95:0]       lanes_q;    // store bytes already placed in their lanes
    logic [11:0]       mask_q;     // matching byte enables across 3 words
    logic [95:0]       buf_q;      // load beats collected so far

    // ------------------------------------------------------------------
    // Accept-time decode (from the live inputs, used only in IDLE)
    // ------------------------------------------------------------------
    logic [3:0]  in_nbytes;
    logic [63:0] in_keep;
    logic [7:0]  in_m8;
    logic [3:0]  in_span;
    logic [3:0]  in_span_up;
    logic [1:0]  in_beats;
    logic [95:0] in_lanes;
    logic [11:0] in_mask;
    logic        in_reject;

    always_comb begin
        in_nbytes = 4'd1;
        in_keep   = 64'h0000_0000_0000_00FF;
        in_m8     = 8'h01;
        case (size)
            2'd0: begin in_nbytes = 4'd1; in_keep = 64'h0000_0000_0000_00FF; in_m8 = 8'h01; end
            2'd1: begin in_nbytes = 4'd2; in_keep = 64'h0000_0000_0000_FFFF; in_m8 = 8'h03; end
            2'd2: begin in_nbytes = 4'd4; in_keep = 64'h0000_0000_FFFF_FFFF; in_m8 = 8'h0F; end
            default: begin in_nbytes = 4'd8; in_keep = 64'hFFFF_FFFF_FFFF_FFFF; in_m8 = 8'hFF; end
        endcase
    end

    // beats = ceil((offset + nbytes) / 4); the sum never exceeds 11
    assign in_span    = {2'b00, addr[1:0]} + in_nbytes;
    assign in_span_up = in_span + 4'd3;
    assign in_beats   = in_span_up[3:2];

    assign in_lanes = {32'h0, wdata & in_keep} << {addr[1:0], 3'b000};
    assign in_mask  = {4'h0, in_m8} << addr[1:0];

`ifdef MEM_MISALIGNED_EN
    assign in_reject = 1'b0;
`else
    always_comb begin
        in_reject = 1'b0;
        case (size)
            2'd0:    in_reject = 1'b0;
            2'd1:    in_reject = addr[0];
            2'd2:    in_reject = |addr[1:0];
            default: in_reject = |addr[2:0];
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Beat sequencing helpers
    // ------------------------------------------------------------------
    logic [1:0] nxt_beat;
    logic [1:0] prev_beat;
    logic [1:0] last_beat;

    assign nxt_beat  = beat_q + 2'd1;
    assign prev_beat = beat_q - 2'd1;
    assign last_beat = beats_q - 2'd1;

    // ------------------------------------------------------------------
    // Load result: the final beat arrives on ram_rdata during WAIT and is
    // merged directly instead of costing an extra capture cycle.
    // ------------------------------------------------------------------
    logic [95:0] assembled;
    logic [95:0] shifted;
    logic [63:0] raw;
    logic [63:0] load_result;

    always_comb begin
        assembled = buf_q;
        assembled[{last_beat, 5'b00000} +: 32] = ram_rdata;
    end

    assign shifted = assembled >> {off_q, 3'b000};
    assign raw     = shifted[63:0];

    always_comb begin
        load_result = raw;
        case (size_q)
            2'd0: load_result = zext_q ? {56'h0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1: load_result = zext_q ? {48'h0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2: load_result = zext_q ? {32'h0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_result = raw;  // double is never extended
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rdata      <= 64'h0;
            done       <= 1'b0;
            busy       <= 1'b0;
            misaligned <= 1'b0;
            ram_addr   <= '0;
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
            ram_be     <= 4'h0;
            ram_wdata  <= 32'h0;
            op_q       <= 1'b0;
            size_q     <= 2'd0;
            zext_q     <= 1'b0;
            off_q      <= 2'd0;
            base_q     <= '0;
            beats_q    <= 2'd1;
            beat_q     <= 2'd0;
            lanes_q    <= 96'h0;
            mask_q     <= 12'h0;
            buf_q      <= 96'h0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q       <= operation;
                        size_q     <= size;
                        zext_q     <= extension[2];
                        off_q      <= addr[1:0];
                        base_q     <= addr[RAM_AW+1:2];
                        beats_q    <= in_beats;
                        beat_q     <= 2'd0;
                        lanes_q    <= in_lanes;
                        mask_q     <= in_mask;
                        misaligned <= in_reject;
                        busy       <= 1'b1;
                        if (in_reject) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            // Beat 0 goes out on the cycle right after accept
                            state    <= S_REQ;
                            ram_addr <= addr[RAM_AW+1:2];
                            ram_we   <= operation;
                            ram_re   <= ~operation;
                            ram_be   <= operation ? in_mask[3:0] : 4'hF;
                            if (operation) begin
                                ram_wdata <= in_lanes[31:0];
                            end
                        end
                    end
                end

                S_REQ: begin
                    // Read data for the previous beat is on ram_rdata now
                    if (!op_q && beat_q != 2'd0) begin
                        buf_q[{prev_beat, 5'b00000} +: 32] <= ram_rdata;
                    end
                    if (nxt_beat < beats_q) begin
                        beat_q   <= nxt_beat;
                        ram_addr <= base_q + RAM_AW'(nxt_beat);  // wraps past the top word
                        ram_we   <= op_q;
                        ram_re   <= ~op_q;
                        ram_be   <= op_q ? mask_q[{nxt_beat, 2'b00} +: 4] : 4'hF;
                        if (op_q) begin
                            ram_wdata <= lanes_q[{nxt_beat, 5'b00000} +: 32];
                        end
                    end else begin
                        ram_we <= 1'b0;
                        ram_re <= 1'b0;
                        ram_be <= 4'h0;
                        if (op_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    rdata <= load_result;
                    state <= S_DONE;
                    done  <= 1'b1;
                end

                default: begin  // S_DONE
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // Address bits above the RAM and the low funct3 bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{addr[63:RAM_AW+2], extension[1:0]};

endmodule

// File: tb/tb_memory_interface.sv
// -----------------------------------------------------------------------------
// tb_memory_interface
//
// Bench for memory_interface. A behavioural SRAM sits on the ram_* port; a
// byte-array reference memory and a load-result model predict every access.
// Directed steps follow the access scenarios, then randomized accesses.
// -----------------------------------------------------------------------------
module tb_memory_interface;
    localparam int RAM_AW = 12;
    localparam int NWORDS = 1 << RAM_AW;
    localparam int NBYTES = NWORDS * 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              start;
    logic              operation;
    logic [1:0]        size;
    logic [2:0]        extension;
    logic [63:0]       addr;
    logic [63:0]       wdata;
    logic [63:0]       rdata;
    logic              done;
    logic              busy;
    logic              misaligned;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [1:0]        state_dbg;

    memory_interface #(.RAM_AW(RAM_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .operation  (operation),
        .size       (size),
        .extension  (extension),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .busy       (busy),
        .misaligned (misaligned),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_be     (ram_be),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .state_dbg  (state_dbg)
    );

    // ---------------- behavioural SRAM ----------------
    logic [31:0] ram [NWORDS];
    logic [31:0] ram_merge;

    always @(posedge clk) begin
        if (ram_we) begin
            ram_merge = ram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ram_merge[8*b +: 8] = ram_wdata[8*b +: 8];
            ram[ram_addr] <= ram_merge;
        end
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]  ref_mem [NBYTES];
    logic [63:0] exp_q[$];
    logic [63:0] model_rdata;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit rejected(input logic [63:0] a, input logic [1:0] sz);
`ifdef MEM_MISALIGNED_EN
        return 1'b0;
`else
        return (a % 64'(nbytes_of(sz))) != 0;
`endif
    endfunction

    function automatic int beats_of(input logic [63:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) + nbytes_of(sz) + 3) / 4;
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a, input logic [1:0] sz,
                                               input logic [2:0] ext);
        logic [63:0] v;
        logic [63:0] ones;
        int n;
        n = nbytes_of(sz);
        v = 64'h0;
        ones = '1;
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = ref_mem[int'((a + 64'(i)) % 64'(NBYTES))];
        if (n < 8 && !ext[2] && v[8*n-1]) v = v | (ones << (8*n));
        return v;
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
        for (int i = 0; i < nbytes_of(sz); i++)
            ref_mem[int'((a + 64'(i)) % 64'(NBYTES))] = wd[8*i +: 8];
    endtask

    function automatic logic [3:0] exp_be(input int o, input int n, input int j);
        logic [3:0] r;
        r = 4'h0;
        for (int b = 0; b < 4; b++)
            if (4*j + b >= o && 4*j + b < o + n) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_lane(input int o, input int n, input int j,
                                             input logic [63:0] wd);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++)
            if (4*j + b >= o && 4*j + b < o + n) r[8*b +: 8] = wd[8*(4*j + b - o) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] be_expand(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // ---------------- driver: one complete access ----------------
    task automatic do_access(input string tag, input logic op, input logic [1:0] sz,
                             input logic [2:0] ext, input logic [63:0] a, input logic [63:0] wd);
        bit  rej;
        int  nb, lat, cyc, strobes, o, n;
        bit  got_done;
        logic [3:0] be_e;
        rej = rejected(a, sz);
        nb  = beats_of(a, sz);
        o   = int'(a[1:0]);
        n   = nbytes_of(sz);
        lat = rej ? 1 : (op ? nb + 1 : nb + 2);
        if (!rej && !op) exp_q.push_back(model_read(a, sz, ext));

        @(negedge clk);
        start = 1'b1; operation = op; size = sz; extension = ext; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
        // scramble request inputs; the access must use the latched copy
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        size = 2'($urandom); extension = 3'($urandom); operation = ~op;
        chk({tag, "_busy"}, 64'(busy), 64'(1));

        cyc = 1; strobes = 0; got_done = 1'b0;
        while (!got_done && cyc <= 20) begin
            if (ram_re || ram_we) begin
                be_e = op ? exp_be(o, n, strobes) : 4'hF;
                chk($sformatf("%s_b%0d_we", tag, strobes), 64'(ram_we), 64'(op));
                chk($sformatf("%s_b%0d_addr", tag, strobes), 64'(ram_addr),
                    64'(((int'(a[RAM_AW+1:2])) + strobes) % NWORDS));
                chk($sformatf("%s_b%0d_be", tag, strobes), 64'(ram_be), 64'(be_e));
                if (op)
                    chk($sformatf("%s_b%0d_wd", tag, strobes),
                        64'(ram_wdata & be_expand(be_e)), 64'(exp_lane(o, n, strobes, wd)));
                strobes++;
            end
            if (done) begin
                got_done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, 64'(got_done), 64'(1));
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_strobes"}, 64'(strobes), 64'(rej ? 0 : nb));
        chk({tag, "_misaligned"}, 64'(misaligned), 64'(rej));
        if (!rej && !op) model_rdata = exp_q.pop_front();
        if (!rej && op) model_write(a, sz, wd);
        chk({tag, "_rdata"}, rdata, model_rdata);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    int dones, t1, t2, mism;
    logic [63:0] ra;
    logic [1:0]  rsz;

    initial begin
        for (int i = 0; i < NWORDS; i++) ram[i] = 32'h0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h0;
        model_rdata = 64'h0;
        start = 1'b0; operation = 1'b0; size = 2'd0; extension = 3'd0;
        addr = 64'h0; wdata = 64'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_ctrl", 64'({done, busy, misaligned, ram_re, ram_we}), 64'(0));
        chk("rst_ram_be", 64'(ram_be), 64'(0));
        chk("rst_ram_addr", 64'(ram_addr), 64'(0));
        chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
        chk("rst_state", 64'(state_dbg), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // store word, then byte/half loads from it
        do_access("sw10", 1'b1, 2'd2, 3'b010, 64'h10, 64'h0000_0000_DEAD_BEEF);
        chk("sw10_word4", 64'(ram[4]), 64'h0000_0000_DEAD_BEEF);
        do_access("lb13", 1'b0, 2'd0, 3'b000, 64'h13, 64'h0);
        chk("lb13_value", rdata, 64'hFFFF_FFFF_FFFF_FFDE);
        do_access("lhu12", 1'b0, 2'd1, 3'b101, 64'h12, 64'h0);
        chk("lhu12_value", rdata, 64'h0000_0000_0000_DEAD);
        do_access("lh12", 1'b0, 2'd1, 3'b001, 64'h12, 64'h0);
        chk("lh12_value", rdata, 64'hFFFF_FFFF_FFFF_DEAD);

        // double store/load
        do_access("sd20", 1'b1, 2'd3, 3'b011, 64'h20, 64'h0123_4567_89AB_CDEF);
        chk("sd20_word8", 64'(ram[8]), 64'h89AB_CDEF);
        chk("sd20_word9", 64'(ram[9]), 64'h0123_4567);
        do_access("ld20", 1'b0, 2'd3, 3'b011, 64'h20, 64'h0);
        chk("ld20_value", rdata, 64'h0123_4567_89AB_CDEF);

        // misaligned word load
        do_access("lw22", 1'b0, 2'd2, 3'b010, 64'h22, 64'h0);
`ifdef MEM_MISALIGNED_EN
        chk("lw22_value", rdata, 64'h0000_0000_4567_89AB);
        do_access("sw3ffe", 1'b1, 2'd2, 3'b010, 64'h3FFE, 64'h0000_0000_1122_3344);
        chk("sw3ffe_top", 64'(ram[NWORDS-1][31:16]), 64'h3344);
        chk("sw3ffe_w0", 64'(ram[0][15:0]), 64'h1122);
`else
        chk("lw22_misaligned", 64'(misaligned), 64'(1));
        do_access("sh13", 1'b1, 2'd1, 3'b001, 64'h13, 64'hFFFF);
        chk("sh13_word4", 64'(ram[4]), 64'h0000_0000_DEAD_BEEF);
`endif

        // start held high across two stores
        @(negedge clk);
        start = 1'b1; operation = 1'b1; size = 2'd2; extension = 3'b010;
        addr = 64'h40; wdata = 64'h0000_0000_CAFE_F00D;
        dones = 0; t1 = 0; t2 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    t1 = c;
                    addr = 64'h44; wdata = 64'h0000_0000_0BAD_C0DE;
                end else if (dones == 2) begin
                    t2 = c;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        model_write(64'h40, 2'd2, 64'h0000_0000_CAFE_F00D);
        model_write(64'h44, 2'd2, 64'h0000_0000_0BAD_C0DE);
        chk("held_dones", 64'(dones), 64'(2));
        chk("held_gap", 64'(t2 - t1), 64'(3));
        chk("held_word16", 64'(ram[16]), 64'h0000_0000_CAFE_F00D);
        chk("held_word17", 64'(ram[17]), 64'h0000_0000_0BAD_C0DE);

        // reset during the first beat of a double store
        @(negedge clk);
        start = 1'b1; operation = 1'b1; size = 2'd3; extension = 3'b011;
        addr = 64'h30; wdata = 64'h1122_3344_5566_7788;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rstmid_first_we", 64'(ram_we), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_we", 64'(ram_we), 64'(0));
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_done", 64'(done), 64'(0));
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done || ram_we || ram_re) dones++;
        end
        chk("rstmid_quiet", 64'(dones), 64'(0));
        chk("rstmid_word12", 64'(ram[12]), 64'h5566_7788);
        chk("rstmid_word13", 64'(ram[13]), 64'h0);
        model_write(64'h30, 2'd2, 64'h5566_7788);
        model_rdata = 64'h0;

        // randomized accesses
        for (int i = 0; i < 40; i++) begin
            rsz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                ra = 64'(NBYTES - 16 + int'($urandom_range(0, 15)));
            else
                ra = 64'(256 + int'($urandom_range(0, 127)));
            if ($urandom_range(0, 3) == 0) ra = ra | (64'($urandom) << 20);
            do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), rsz,
                      3'($urandom), ra, {$urandom, $urandom});
        end

        // whole-RAM image against the byte model
        mism = 0;
        for (int w = 0; w < NWORDS; w++)
            if (ram[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
                mism++;
        chk("ram_image", 64'(mism), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
